// File: rtl/pio_out_pulse.sv
// Avalon-MM general-purpose output port with atomic set/clear registers
// and a hardware-timed inverting pulse.
module pio_out_pulse #(
    parameter int unsigned WIDTH        = 8,
    parameter logic [31:0] RESET_VALUE  = 32'h0,
    parameter int unsigned PULSE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam int unsigned     CntW    = $clog2(PULSE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLoad = CntW'(PULSE_CYCLES - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [31:0]      rd_q, rd_d;

    logic             wr;
    logic             pulse_wr;
    logic [WIDTH-1:0] wd;

    // Bits above WIDTH are ignored by design.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign wr = chipselect & ~write_n;
    assign wd = writedata[WIDTH-1:0];
    // An all-zero pulse write only matters if it restarts a running pulse.
    assign pulse_wr = wr && (address == 2'd3) && (busy_q || (wd != '0));

    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;

        if (wr) begin
            case (address)
                2'd0:    data_d = wd;
                2'd1:    data_d = data_q | wd;
                2'd2:    data_d = data_q & ~wd;
                default: ;
            endcase
        end

        if (pulse_wr) begin
            mask_d = mask_q | wd;
            cnt_d  = CntLoad;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                mask_d = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        out_d = data_d ^ (busy_d ? mask_d : '0);

        // Reads observe the state before this cycle's write.
        case (address)
            2'd0:    rd_d = 32'(data_q);
            2'd1:    rd_d = 32'(out_q);
            2'd2:    rd_d = {31'b0, busy_q};
            default: rd_d = 32'(mask_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE[WIDTH-1:0];
            mask_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            out_q  <= RESET_VALUE[WIDTH-1:0];
            rd_q   <= '0;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            out_q  <= out_d;
            rd_q   <= rd_d;
        end
    end

    assign out_port = out_q;
    assign readdata = rd_q;

endmodule
